// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider width, FSM states and the
// quotient value reported for a division by zero.
package arith_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when no borrow occurs.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        trial   = {r_i, q_msb_i};
        diff    = {1'b0, trial} - {2'b00, divisor_i};
        borrow  = diff[WIDTH+1];
        r_o     = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        q_bit_o = ~borrow;
    end

endmodule

// File: rtl/iterative_divider.sv
// Sequential unsigned divider: WIDTH-cycle restoring division behind
// valid/ready request and response handshakes.
module iterative_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i       (r_q),
        .q_msb_i   (q_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .r_o       (step_r),
        .q_bit_o   (step_bit)
    );

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        dvs_d   = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - 1'b1;
                // Final iteration writes the result registers directly.
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = {q_q[WIDTH-2:0], step_bit};
                    remainder_d = step_r;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed requests push expected
// results, an independent monitor checks every presented response.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;   // edges after the accept edge at which DONE is entered
        int          acc;
    } exp_t;

    exp_t sb[$];

    iterative_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per response and checks it stays held.
    exp_t cur;
    bit   have_cur   = 0;
    bit   checked    = 0;
    bit   ready_next = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            checked    = 0;
            ready_next = 0;
            have_cur   = 0;
        end else begin
            if (ready_next) begin
                chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
                ready_next = 0;
            end
            if (out_valid) begin
                if (!checked) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 0;
                        $display("FAIL unexpected_output q=%0h r=%0h (cycle %0d)", quotient, remainder, cyc);
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1;
                        chk("quotient",    64'(quotient),    64'(cur.q));
                        chk("remainder",   64'(remainder),   64'(cur.r));
                        chk("div_by_zero", 64'(div_by_zero), 64'(cur.dbz));
                        chk("latency",     64'(cyc - cur.acc), 64'(cur.lat));
                        if (!cur.dbz) begin
                            chk("inv_reconstruct",
                                64'(quotient) * 64'(cur.b) + 64'(remainder), 64'(cur.a));
                            chk("inv_rem_lt_div", 64'(remainder < cur.b), 64'd1);
                        end
                    end
                    checked = 1;
                end else if (have_cur) begin
                    chk("hold_quotient",  64'(quotient),  64'(cur.q));
                    chk("hold_remainder", 64'(remainder), 64'(cur.r));
                    chk("hold_dbz",       64'(div_by_zero), 64'(cur.dbz));
                end
                if (out_ready) begin
                    checked    = 0;
                    ready_next = 1;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r,
                         input logic dbz, input int lat, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e = '{a: a, b: b, q: q, r: r, dbz: dbz, lat: lat, acc: cyc};
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),    64'd1);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_quotient",  64'(quotient),    64'd0);
        chk("rst_remainder", 64'(remainder),   64'd0);
        chk("rst_dbz",       64'(div_by_zero), 64'd0);
        rst_n = 1'b1;

        issue(32'd100,        32'd7,          32'd14,         32'd2,  1'b0, 32, 1);
        issue(32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0, 32, 1);
        issue(32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0, 32, 1);
        issue(32'h8000_0000,  32'h10,         32'h0800_0000,  32'd0,  1'b0, 32, 1);
        issue(32'd3,          32'd10,         32'd0,          32'd3,  1'b0, 32, 1);
        issue(32'd12345,      32'd123,        32'd100,        32'd45, 1'b0, 32, 1);
        issue(32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  1'b1, 0,  1);
        issue(32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,  1'b1, 0,  1);
        drain();

        // Backpressure: hold the response for five cycles while poking in_valid.
        out_ready = 1'b0;
        issue(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 32, 1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
        end
        repeat (5) begin
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            dividend = 32'd7;
            divisor  = 32'd1;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during CALC aborts the operation without a stale response.
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        chk("postrst_in_ready",  64'(in_ready),  64'd1);
        issue(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 32, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
